lifo_rr_scheduler: RTL and testbench

- Shares one LIFO buffer between N_REQ requesters. Each requester issues push or pop requests.
- Round-robin arbitration grants at most one LIFO operation per cycle.
- Keeps a mirror occupancy count, so push-when-full and pop-when-empty are never granted, despite registered issue latency.
- Sits between the requesters and the LIFO's write/read/data_in/data_out/val/full/reset interface, and also generates that buffer's synchronous reset.

---
 rtl/lifo_rr_scheduler_pkg.sv | 19 +
 rtl/lifo_rr_scheduler_arb.sv | 43 ++++
 rtl/lifo_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_lifo_rr_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_rr_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// lifo_rr_scheduler_pkg
// Shared definitions for the LIFO round-robin scheduler and its arbiter.
//   OP_PUSH / OP_POP : encoding of the per-requester op input
//   RR_PTR_W         : round-robin pointer width, sized for up to 16 requesters
//   level_width()    : width of an occupancy count able to hold 0..depth
// ----------------------------------------------------------------------------
package lifo_rr_scheduler_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int RR_PTR_W = 4;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lifo_rr_scheduler_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter_mask
// Purely combinational round-robin arbiter. Searches the request mask starting
// at the pointer position and returns the first set bit as a one-hot grant.
//   req_mask    in  N      requests already qualified by the caller
//   ptr         in  PTR_W  index where the search starts
//   grant       out N      one-hot grant (all zero when nothing requested)
//   grant_valid out 1      a grant was issued
//   ptr_next    out PTR_W  winner+1 mod N, or ptr when nothing was granted
// ----------------------------------------------------------------------------
module rr_arbiter_mask
    import lifo_rr_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = RR_PTR_W
) (
    input  logic [N-1:0]     req_mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [PTR_W-1:0] ptr_next
);

    int idx;
    int win;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        win         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req_mask[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                win         = idx;
            end
        end
        ptr_next = grant_valid ? PTR_W'((win + 1) % N) : ptr;
    end

endmodule

// File: rtl/lifo_rr_scheduler.sv
// ----------------------------------------------------------------------------
// lifo_rr_scheduler
// Shares one LIFO between N_REQ requesters. At most one push or pop is issued
// per cycle, chosen round-robin. A mirror occupancy count (level) is updated in
// the grant cycle itself, so the registered issue latency can never let a push
// hit a full LIFO or a pop hit an empty one. Also generates the LIFO's reset.
//   clk, reset        clock, asynchronous active-low reset
//   req/op/wdata      per-requester request, op (0 push, 1 pop), push data
//   ack               one-cycle grant pulse, the cycle after the grant
//   rdata/rvalid      pop data (broadcast) and one-hot owner, 2 cycles after grant
//   level             mirror occupancy
//   lifo_*            LIFO interface; lifo_val/lifo_full are debug-only inputs
// ----------------------------------------------------------------------------
module lifo_rr_scheduler
    import lifo_rr_scheduler_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int LIFO_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          op,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rvalid,
    output logic [$clog2(LIFO_SIZE):0] level,
    output logic                      lifo_reset,
    output logic                      lifo_write,
    output logic                      lifo_read,
    output logic [DATA_W-1:0]         lifo_data_in,
    input  logic [DATA_W-1:0]         lifo_data_out,
    input  logic                      lifo_val,
    input  logic                      lifo_full
);

    localparam int LEVEL_W = level_width(LIFO_SIZE);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(LIFO_SIZE);

    logic [1:0]          rst_sync_q;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [RR_PTR_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    grant;
    logic                grant_valid;
    logic [RR_PTR_W-1:0] ptr_next;
    logic                gnt_op;
    logic [DATA_W-1:0]   gnt_wdata;

    // val/full are kept for debug visibility only; arbitration trusts level.
    logic unused_debug;
    assign unused_debug = lifo_val ^ lifo_full;

    // LIFO reset: forced high asynchronously, released after two clean edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b11;
        else        rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign lifo_reset = rst_sync_q[1];

    // A requester in its own ack cycle is masked so a held req is not
    // re-granted for the operation that was just acknowledged.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !ack_q[i] && !lifo_reset) begin
                eligible[i] = (op[i] == OP_PUSH) ? (level_q != LEVEL_FULL)
                                                 : (level_q != '0);
            end
        end
    end

    rr_arbiter_mask #(
        .N     (N_REQ),
        .PTR_W (RR_PTR_W)
    ) u_arb (
        .req_mask    (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid),
        .ptr_next    (ptr_next)
    );

    always_comb begin
        gnt_op    = 1'b0;
        gnt_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_op    = op[i];
                gnt_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ack_d    = grant_valid ? grant : '0;
        wr_d     = grant_valid && (gnt_op == OP_PUSH);
        rd_d     = grant_valid && (gnt_op == OP_POP);
        din_d    = wr_d ? gnt_wdata : din_q;
        ptr_d    = ptr_next;
        level_d  = level_q;
        if (wr_d)      level_d = level_q + LEVEL_W'(1);
        else if (rd_d) level_d = level_q - LEVEL_W'(1);
        // Pop data is on lifo_data_out while lifo_read is high; the owner is
        // the requester whose ack is in the same cycle.
        rvalid_d = rd_q ? ack_q : '0;
        rdata_d  = rd_q ? lifo_data_out : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            level_q  <= '0;
            ptr_q    <= '0;
        end else begin
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            din_q    <= din_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            ptr_q    <= ptr_d;
        end
    end

    assign ack          = ack_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign level        = level_q;
    assign lifo_write   = wr_q;
    assign lifo_read    = rd_q;
    assign lifo_data_in = din_q;

endmodule

// File: tb/tb_lifo_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lifo_rr_scheduler
// Drives lifo_rr_scheduler with directed scenarios followed by random traffic.
// A behavioural LIFO stands in for the real buffer, and a reference model
// (queue-based stack, integer level and pointer) predicts every output cycle.
// ----------------------------------------------------------------------------
module tb_lifo_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   op;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]   ack;
    logic [DW-1:0]  rdata;
    logic [N-1:0]   rvalid;
    logic [3:0]     level;
    logic           lifo_reset;
    logic           lifo_write;
    logic           lifo_read;
    logic [DW-1:0]  lifo_data_in;
    logic [DW-1:0]  lifo_data_out;
    logic           lifo_val;
    logic           lifo_full;

    lifo_rr_scheduler #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .LIFO_SIZE (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .op            (op),
        .wdata         (wdata),
        .ack           (ack),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .level         (level),
        .lifo_reset    (lifo_reset),
        .lifo_write    (lifo_write),
        .lifo_read     (lifo_read),
        .lifo_data_in  (lifo_data_in),
        .lifo_data_out (lifo_data_out),
        .lifo_val      (lifo_val),
        .lifo_full     (lifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LIFO attached to the scheduler.
    logic [DW-1:0] env_mem [DEPTH];
    int            env_cnt = 0;

    always @(posedge clk) begin
        if (lifo_reset) begin
            env_cnt <= 0;
        end else if (lifo_write && env_cnt < DEPTH) begin
            env_mem[env_cnt] <= lifo_data_in;
            env_cnt <= env_cnt + 1;
        end else if (lifo_read && env_cnt > 0) begin
            env_cnt <= env_cnt - 1;
        end
    end
    assign lifo_data_out = (env_cnt > 0) ? env_mem[env_cnt-1] : '0;
    assign lifo_full     = (env_cnt == DEPTH);
    assign lifo_val      = (env_cnt > 0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: current-cycle expectations (e_*) and next-cycle (n_*).
    logic [N-1:0]  e_ack, n_ack, e_rvalid, n_rvalid;
    logic [DW-1:0] e_rdata, n_rdata, e_din, n_din, e_pv, n_pv;
    logic          e_wr, n_wr, e_rd, n_rd, e_lrst;
    int            e_level, n_level, m_ptr, n_ptr, rel_edges;
    logic [DW-1:0] stk [$];
    bit            rand_mode = 0;

    task automatic model_reset();
        e_ack = '0; e_rvalid = '0; e_rdata = '0; e_din = '0; e_pv = '0;
        e_wr = 1'b0; e_rd = 1'b0; e_level = 0; e_lrst = 1'b1;
        m_ptr = 0; rel_edges = 0;
        stk.delete();
    endtask

    task automatic model_next();
        int w;
        w = -1;
        n_ack = '0; n_wr = 1'b0; n_rd = 1'b0;
        n_din = e_din; n_level = e_level; n_ptr = m_ptr; n_pv = e_pv;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && req[i] && !e_ack[i] && !e_lrst &&
                    (op[i] ? (e_level > 0) : (e_level < DEPTH)))
                    w = i;
            end
        end
        if (w >= 0) begin
            n_ack[w] = 1'b1;
            n_ptr = (w + 1) % N;
            if (!op[w]) begin
                n_wr = 1'b1;
                n_din = wdata[w*DW +: DW];
                n_level = e_level + 1;
                stk.push_back(n_din);
            end else begin
                n_rd = 1'b1;
                n_level = e_level - 1;
                n_pv = stk.pop_back();
            end
        end
        n_rvalid = e_rd ? e_ack : '0;
        n_rdata  = e_rd ? e_pv : e_rdata;
    endtask

    task automatic model_apply();
        if (!reset) begin
            model_reset();
        end else begin
            e_ack = n_ack; e_wr = n_wr; e_rd = n_rd; e_din = n_din;
            e_level = n_level; m_ptr = n_ptr; e_pv = n_pv;
            e_rvalid = n_rvalid; e_rdata = n_rdata;
            if (rel_edges < 2) rel_edges++;
            e_lrst = (rel_edges < 2);
        end
    endtask

    task automatic check_all();
        chk("ack", ack, e_ack);
        chk("rvalid", rvalid, e_rvalid);
        chk("rdata", rdata, e_rdata);
        chk("level", level, e_level);
        chk("lifo_reset", lifo_reset, e_lrst);
        chk("lifo_write", lifo_write, e_wr);
        chk("lifo_read", lifo_read, e_rd);
        chk("lifo_data_in", lifo_data_in, e_din);
        chk("write_when_full", lifo_write & lifo_full, 1'b0);
    endtask

    task automatic drive_requesters();
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i]) begin
                if (!rand_mode || $urandom_range(0, 1) == 0) req[i] = 1'b0;
            end else if (!req[i] && rand_mode && $urandom_range(0, 3) == 0) begin
                op[i] = 1'($urandom_range(0, 1));
                wdata[i*DW +: DW] = 8'($urandom);
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        model_apply();
        #1;
        check_all();
        drive_requesters();
    endtask

    task automatic set_req(input int i, input logic o, input logic [DW-1:0] d);
        req[i] = 1'b1;
        op[i] = o;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(input int i, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack[i] && n < 20);
        chk(tag, ack[i], 1'b1);
    endtask

    task automatic do_reset_assert();
        req = '0;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic reset_pulse(input int cycles);
        do_reset_assert();
        repeat (cycles) tick();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    logic [DW-1:0] seq_din [$];
    logic [N-1:0]  seq_ack [$];

    initial begin
        reset = 1'b1;
        req = '0; op = '0; wdata = '0;
        model_reset();
        #1 reset = 1'b0;
        #1;
        check_all();

        // Reset release with all four requesters pushing 10..13.
        req = 4'b1111; op = 4'b0000; wdata = 32'h13121110;
        repeat (3) begin
            tick();
            chk("rst_ack", ack, 4'b0000);
            chk("rst_lifo_reset", lifo_reset, 1'b1);
        end
        reset = 1'b1;
        tick();
        chk("rel_edge1", lifo_reset, 1'b1);
        tick();
        chk("rel_edge2", lifo_reset, 1'b0);
        chk("rel_no_ack", ack, 4'b0000);
        for (int k = 0; k < 12 && seq_din.size() < 4; k++) begin
            tick();
            if (lifo_write) begin
                seq_din.push_back(lifo_data_in);
                seq_ack.push_back(ack);
            end
        end
        chk("rr_count", seq_din.size(), 4);
        for (int k = 0; k < seq_din.size(); k++) begin
            chk("rr_din", seq_din[k], 8'h10 + k);
            chk("rr_ack", seq_ack[k], 1 << k);
        end
        chk("rr_level", level, 4);

        // Full blocking.
        reset_pulse(2);
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b0, 8'(k));
            wait_ack(0, "fill_ack");
        end
        chk("fill_level", level, 8);
        set_req(2, 1'b0, 8'hAA);
        repeat (4) begin
            tick();
            chk("full_no_ack2", ack[2], 1'b0);
            chk("full_level", level, 8);
        end
        set_req(0, 1'b1, 8'h00);
        wait_ack(0, "full_pop_ack");
        tick();
        chk("full_pop_rvalid", rvalid, 4'b0001);
        chk("full_pop_rdata", rdata, 8'h07);
        chk("full_ack2_next", ack, 4'b0100);

        // Empty blocking.
        reset_pulse(2);
        set_req(1, 1'b1, 8'h00);
        set_req(3, 1'b0, 8'h5C);
        wait_ack(3, "empty_ack3");
        chk("empty_ack_first", ack, 4'b1000);
        tick();
        chk("empty_ack1", ack, 4'b0010);
        tick();
        chk("empty_rvalid", rvalid, 4'b0010);
        chk("empty_rdata", rdata, 8'h5C);
        chk("empty_level", level, 0);

        // Two pushes at level 7: only one fits.
        reset_pulse(2);
        for (int k = 0; k < 7; k++) begin
            set_req(3, 1'b0, 8'h30 + 8'(k));
            wait_ack(3, "b2b_fill_ack");
        end
        set_req(0, 1'b0, 8'hE0);
        set_req(1, 1'b0, 8'hE1);
        tick();
        chk("b2b_one_ack", ack, 4'b0001);
        chk("b2b_level", level, 8);
        repeat (3) begin
            tick();
            chk("b2b_stall1", ack[1], 1'b0);
        end
        set_req(3, 1'b1, 8'h00);
        wait_ack(1, "b2b_late_ack1");

        // Reset in the cycle after a pop grant.
        set_req(2, 1'b1, 8'h00);
        wait_ack(2, "mid_pop_ack");
        do_reset_assert();
        chk("mid_lifo_reset", lifo_reset, 1'b1);
        chk("mid_level", level, 0);
        repeat (3) begin
            tick();
            chk("mid_rvalid", rvalid, 4'b0000);
        end
        reset = 1'b1;
        repeat (3) tick();

        // Random traffic with occasional resets.
        rand_mode = 1;
        repeat (1500) begin
            tick();
            if ($urandom_range(0, 299) == 0) reset_pulse(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
